// File: rtl/slot_pkg.sv
// -----------------------------------------------------------------------------
// slot_pkg
// Types, widths, payout defaults and the scoring function shared by the
// slot-machine spin controller and its reel sub-module.
// -----------------------------------------------------------------------------
package slot_pkg;

    localparam int REEL_W            = 4;
    localparam int CREDIT_W          = 8;
    localparam int PAYOUT_TRIPLE_DEF = 10;
    localparam int PAYOUT_PAIR_DEF   = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPIN3 = 3'd1,
        ST_SPIN2 = 3'd2,
        ST_SPIN1 = 3'd3,
        ST_EVAL  = 3'd4
    } slot_state_t;

    // Three of a kind beats a pair; a pair is any two reels equal.
    function automatic logic [CREDIT_W-1:0] payout_f(
        input logic [REEL_W-1:0]   a,
        input logic [REEL_W-1:0]   b,
        input logic [REEL_W-1:0]   c,
        input logic [CREDIT_W-1:0] triple_amt,
        input logic [CREDIT_W-1:0] pair_amt
    );
        logic [CREDIT_W-1:0] result;
        if ((a == b) && (b == c)) begin
            result = triple_amt;
        end else if ((a == b) || (b == c) || (a == c)) begin
            result = pair_amt;
        end else begin
            result = '0;
        end
        return result;
    endfunction

endpackage

// File: rtl/slot_spin_controller_reel.sv
// -----------------------------------------------------------------------------
// slot_reel
// One reel: a value register that, while moving, advances on each tick by
// 1 + step_extra and wraps modulo REEL_MAX+1. When not moving the value holds.
// Ports:
//   clk, rst_n   clock, async active-low reset (value resets to 0)
//   move         reel is spinning
//   tick         reel-advance tick
//   step_extra   additional step (0..3) added on top of the base +1
//   value        current reel value
// -----------------------------------------------------------------------------
module slot_reel
    import slot_pkg::*;
#(
    parameter int REEL_MAX = 9
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              move,
    input  logic              tick,
    input  logic [1:0]        step_extra,
    output logic [REEL_W-1:0] value
);

    logic [REEL_W-1:0] value_q, value_d;
    logic [REEL_W:0]   sum;
    logic [REEL_W:0]   wrapped;

    // Modulo by a constant keeps the wrap correct even if a large step
    // crosses REEL_MAX more than once for small REEL_MAX.
    always_comb begin
        sum     = {1'b0, value_q} + (REEL_W+1)'(step_extra) + (REEL_W+1)'(1);
        wrapped = sum % (REEL_W+1)'(REEL_MAX + 1);
        value_d = value_q;
        if (move && tick) begin
            value_d = wrapped[REEL_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/slot_spin_controller.sv
// -----------------------------------------------------------------------------
// slot_spin_controller
// Runs one slot-machine round: a spin request debits a credit, three reels
// animate, reels freeze in order 1,2,3 on stop presses or auto-timeout, then
// the final triple is scored and the payout credited (saturating at 255).
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   spin_btn, stop_btn            synchronous levels, rising edge acts
//   slot1_num..slot3_num          reel values to the display encoder
//   credits                       credit balance
//   busy                          round in progress
//   win_pulse                     one cycle when a nonzero payout lands
//   win_amount                    last payout, cleared on next accepted spin
// Build option: define SLOT_LFSR_STEP_EN to give each reel a pseudo-random
// per-tick step of 1..4 from a free-running 8-bit LFSR.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_IDLE  | waiting for a spin edge with credits > 0
// ST_SPIN3 | reels 1,2,3 moving
// ST_SPIN2 | reels 2,3 moving
// ST_SPIN1 | reel 3 moving
// ST_EVAL  | one cycle: score triple, credit payout
// -----------------------------------------------------------------------------
module slot_spin_controller
    import slot_pkg::*;
#(
    parameter int REEL_MAX        = 9,
    parameter int TICK_DIV        = 2500000,
    parameter int AUTO_STOP_TICKS = 40,
    parameter int INIT_CREDITS    = 10,
    parameter int PAYOUT_TRIPLE   = PAYOUT_TRIPLE_DEF,
    parameter int PAYOUT_PAIR     = PAYOUT_PAIR_DEF
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spin_btn,
    input  logic                stop_btn,
    output logic [REEL_W-1:0]   slot1_num,
    output logic [REEL_W-1:0]   slot2_num,
    output logic [REEL_W-1:0]   slot3_num,
    output logic [CREDIT_W-1:0] credits,
    output logic                busy,
    output logic                win_pulse,
    output logic [CREDIT_W-1:0] win_amount
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AUTO_W = $clog2(AUTO_STOP_TICKS + 1);

    slot_state_t         state_q, state_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [AUTO_W-1:0]   auto_cnt_q, auto_cnt_d;
    logic                spin_prev_q, spin_prev_d;
    logic                stop_prev_q, stop_prev_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic                busy_q, busy_d;
    logic                win_pulse_q, win_pulse_d;
    logic [CREDIT_W-1:0] win_amount_q, win_amount_d;

    logic                spin_edge, stop_edge, spinning, tick, auto_hit, stop_evt;
    logic                move1, move2, move3;
    logic [1:0]          step1, step2, step3;
    logic [CREDIT_W-1:0] payout;
    logic [CREDIT_W:0]   credit_sum;

    assign spin_edge = spin_btn & ~spin_prev_q;
    assign stop_edge = stop_btn & ~stop_prev_q;
    assign spinning  = state_q inside {ST_SPIN3, ST_SPIN2, ST_SPIN1};
    assign tick      = spinning && (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign auto_hit  = spinning && (auto_cnt_q == AUTO_W'(AUTO_STOP_TICKS));
    // A press and a timeout in the same cycle collapse into one stop.
    assign stop_evt  = spinning && (stop_edge || auto_hit);

    // Reel enables come from the current state, so the reel being stopped
    // still takes a coincident tick before it freezes.
    assign move1 = (state_q == ST_SPIN3);
    assign move2 = (state_q == ST_SPIN3) || (state_q == ST_SPIN2);
    assign move3 = spinning;

`ifdef SLOT_LFSR_STEP_EN
    logic [7:0] lfsr_q, lfsr_d;

    // x^8+x^6+x^5+x^4+1, Fibonacci form; free-running in every state.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign step1 = lfsr_q[1:0];
    assign step2 = lfsr_q[3:2];
    assign step3 = lfsr_q[5:4];
`else
    assign step1 = 2'd0;
    assign step2 = 2'd0;
    assign step3 = 2'd0;
`endif

    slot_reel #(.REEL_MAX(REEL_MAX)) u_reel1 (
        .clk(clk), .rst_n(rst_n), .move(move1), .tick(tick),
        .step_extra(step1), .value(slot1_num)
    );
    slot_reel #(.REEL_MAX(REEL_MAX)) u_reel2 (
        .clk(clk), .rst_n(rst_n), .move(move2), .tick(tick),
        .step_extra(step2), .value(slot2_num)
    );
    slot_reel #(.REEL_MAX(REEL_MAX)) u_reel3 (
        .clk(clk), .rst_n(rst_n), .move(move3), .tick(tick),
        .step_extra(step3), .value(slot3_num)
    );

    assign payout     = payout_f(slot1_num, slot2_num, slot3_num,
                                 CREDIT_W'(PAYOUT_TRIPLE), CREDIT_W'(PAYOUT_PAIR));
    assign credit_sum = {1'b0, credits_q} + {1'b0, payout};

    always_comb begin
        state_d      = state_q;
        spin_prev_d  = spin_btn;
        stop_prev_d  = stop_btn;
        credits_d    = credits_q;
        busy_d       = busy_q;
        win_pulse_d  = 1'b0;
        win_amount_d = win_amount_q;
        tick_cnt_d   = '0;
        auto_cnt_d   = '0;

        if (spinning) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
            if (stop_evt) begin
                auto_cnt_d = '0;
            end else if (tick) begin
                auto_cnt_d = auto_cnt_q + AUTO_W'(1);
            end else begin
                auto_cnt_d = auto_cnt_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (spin_edge && (credits_q != '0)) begin
                    credits_d    = credits_q - CREDIT_W'(1);
                    win_amount_d = '0;
                    busy_d       = 1'b1;
                    state_d      = ST_SPIN3;
                end
            end
            ST_SPIN3: if (stop_evt) state_d = ST_SPIN2;
            ST_SPIN2: if (stop_evt) state_d = ST_SPIN1;
            ST_SPIN1: if (stop_evt) state_d = ST_EVAL;
            ST_EVAL: begin
                credits_d    = credit_sum[CREDIT_W] ? '1 : credit_sum[CREDIT_W-1:0];
                win_amount_d = payout;
                win_pulse_d  = (payout != '0);
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            auto_cnt_q   <= '0;
            spin_prev_q  <= 1'b0;
            stop_prev_q  <= 1'b0;
            credits_q    <= CREDIT_W'(INIT_CREDITS);
            busy_q       <= 1'b0;
            win_pulse_q  <= 1'b0;
            win_amount_q <= '0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            auto_cnt_q   <= auto_cnt_d;
            spin_prev_q  <= spin_prev_d;
            stop_prev_q  <= stop_prev_d;
            credits_q    <= credits_d;
            busy_q       <= busy_d;
            win_pulse_q  <= win_pulse_d;
            win_amount_q <= win_amount_d;
        end
    end

    assign credits    = credits_q;
    assign busy       = busy_q;
    assign win_pulse  = win_pulse_q;
    assign win_amount = win_amount_q;

endmodule

// File: tb/tb_slot_spin_controller.sv
// -----------------------------------------------------------------------------
// tb_slot_spin_controller
// Scoreboard bench: each issued round pushes its expected end-of-round
// outputs; a monitor pops and compares when busy falls.
// Settings: TICK_DIV=4, AUTO_STOP_TICKS=5, LFSR step disabled.
// With TICK_DIV=4 and SPIN3 entered in cycle S, ticks fire in cycles
// S+3, S+7, ...; auto stops land at S+20, S+40, S+60.
// -----------------------------------------------------------------------------
module tb_slot_spin_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spin_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic [3:0] slot1_num, slot2_num, slot3_num;
    logic [7:0] credits, win_amount;
    logic       busy, win_pulse;

    always #5 clk = ~clk;

    slot_spin_controller #(
        .REEL_MAX(9), .TICK_DIV(4), .AUTO_STOP_TICKS(5), .INIT_CREDITS(10),
        .PAYOUT_TRIPLE(10), .PAYOUT_PAIR(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .spin_btn(spin_btn), .stop_btn(stop_btn),
        .slot1_num(slot1_num), .slot2_num(slot2_num), .slot3_num(slot3_num),
        .credits(credits), .busy(busy), .win_pulse(win_pulse),
        .win_amount(win_amount)
    );

    typedef struct {
        int s1; int s2; int s3; int cr; int wa; int wp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   r1 = 0, r2 = 0, r3 = 0, cr_m = 10;
    bit   busy_prev = 0;
    bit   pulse_chk = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int ticks_at(input int m);
        return (m >= 3) ? ((m - 3) / 4 + 1) : 0;
    endfunction

    // Monitor: round completes when busy falls outside reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = 0;
            pulse_chk = 0;
        end else begin
            if (pulse_chk) begin
                check("win_pulse_width", win_pulse, 0);
                pulse_chk = 0;
            end
            if (busy_prev && !busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_round_end", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_slot1", slot1_num, e.s1);
                    check("sb_slot2", slot2_num, e.s2);
                    check("sb_slot3", slot3_num, e.s3);
                    check("sb_credits", credits, e.cr);
                    check("sb_win_amount", win_amount, e.wa);
                    check("sb_win_pulse", win_pulse, e.wp);
                    pulse_chk = 1;
                end
            end
            busy_prev = busy;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_slot1"}, slot1_num, 0);
        check({tag, "_slot2"}, slot2_num, 0);
        check({tag, "_slot3"}, slot3_num, 0);
        check({tag, "_credits"}, credits, 10);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_win_amount"}, win_amount, 0);
        check({tag, "_win_pulse"}, win_pulse, 0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_round_done"}, busy, 0);
    endtask

    // m1..m3: cycle offsets from SPIN3 entry at which each reel stops.
    // press[k]=1 drives a stop edge there; otherwise the auto-stop is expected.
    task automatic run_round(input int m1, input int m2, input int m3,
                             input bit [2:0] press, input bit spin_mid,
                             input string tag);
        int   m[3];
        int   s;
        int   pay;
        int   cr_before;
        exp_t e;
        m  = '{m1, m2, m3};
        r1 = (r1 + ticks_at(m1)) % 10;
        r2 = (r2 + ticks_at(m2)) % 10;
        r3 = (r3 + ticks_at(m3)) % 10;
        if (r1 == r2 && r2 == r3)                 pay = 10;
        else if (r1 == r2 || r2 == r3 || r1 == r3) pay = 2;
        else                                       pay = 0;
        cr_before = cr_m;
        cr_m = cr_m - 1 + pay;
        if (cr_m > 255) cr_m = 255;
        e = '{r1, r2, r3, cr_m, pay, (pay != 0) ? 1 : 0};
        exp_q.push_back(e);

        spin_btn = 1'b1;
        @(posedge clk); #1;
        spin_btn = 1'b0;
        s = cyc;
        check({tag, "_busy_on"}, busy, 1);
        check({tag, "_debit"}, credits, cr_before - 1);
        for (int k = 0; k < 3; k++) begin
            if (press[k]) begin
                while (cyc < s + m[k]) begin @(posedge clk); #1; end
                stop_btn = 1'b1;
                @(posedge clk); #1;
                stop_btn = 1'b0;
                if (k == 0 && spin_mid) begin
                    spin_btn = 1'b1;
                    @(posedge clk); #1;
                    spin_btn = 1'b0;
                    @(posedge clk); #1;
                    check({tag, "_spin_in_spin2_credits"}, credits, cr_before - 1);
                    check({tag, "_spin_in_spin2_busy"}, busy, 1);
                end
            end
        end
        wait_idle(tag);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("reset");

        // Auto-stop only from (0,0,0): 5/10/15 ticks -> (5,0,5), pair.
        run_round(20, 40, 60, 3'b000, 1'b0, "auto_a");
        check("auto_a_triple", slot1_num * 100 + slot2_num * 10 + slot3_num, 505);
        check("auto_a_credits", credits, 11);
        check("auto_a_win_amount", win_amount, 2);

        // Presses at +8 (2 ticks), +27 (7), +47 (12, tick coincident) -> 7,7,7.
        run_round(8, 27, 47, 3'b111, 1'b1, "press_777");
        check("press_777_triple", slot1_num * 100 + slot2_num * 10 + slot3_num, 777);
        check("press_777_credits", credits, 20);
        check("press_777_win_amount", win_amount, 10);

        // Press at +20 coincides with the auto-timeout: one stop only.
        run_round(20, 40, 60, 3'b001, 1'b0, "coincide");
        check("coincide_triple", slot1_num * 100 + slot2_num * 10 + slot3_num, 272);
        check("coincide_credits", credits, 21);

        // Move to (3,9,5); auto rounds then alternate (8,9,0)/(3,9,5), no match.
        run_round(3, 7, 11, 3'b111, 1'b0, "nomatch");
        check("nomatch_win_amount", win_amount, 0);
        while (cr_m > 0) run_round(20, 40, 60, 3'b000, 1'b0, "drain");
        check("drain_credits", credits, 0);

        // Zero credits: spin request ignored.
        spin_btn = 1'b1;
        @(posedge clk); #1;
        spin_btn = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("zero_busy", busy, 0);
        check("zero_credits", credits, 0);

        // Refill by reset, then abort a round in SPIN1 with an async reset.
        rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("reset2");
        spin_btn = 1'b1;
        @(posedge clk); #1;
        spin_btn = 1'b0;
        begin
            int s;
            s = cyc;
            for (int k = 0; k < 2; k++) begin
                while (cyc < s + 3 + 2 * k) begin @(posedge clk); #1; end
                stop_btn = 1'b1;
                @(posedge clk); #1;
                stop_btn = 1'b0;
            end
            while (cyc < s + 8) begin @(posedge clk); #1; end
        end
        check("spin1_busy_before_abort", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        r1 = 0; r2 = 0; r3 = 0; cr_m = 10;

        // Alternating pair/triple auto rounds climb 10 -> 250, then saturate.
        for (int i = 0; i < 51; i++) run_round(20, 40, 60, 3'b000, 1'b0, "sat");
        check("sat_credits", credits, 255);

        repeat (3) begin @(posedge clk); #1; end
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
